// File: rtl/spi_share_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters,
// with per-transaction timeout and an enforced idle gap between transactions.
module spi_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 20,
    parameter int GAP_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [NUM_REQ-1:0]       rsp_timeout,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy,
    output logic                     spi_wren,
    output logic [WIDTH-1:0]         spi_di,
    input  logic                     spi_do_valid,
    input  logic [WIDTH-1:0]         spi_do,
    input  logic                     spi_ssel_n,
    output logic [NUM_REQ-1:0]       ss_n_o
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] next_win;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] data_arr [NUM_REQ];

    // Search starts just after the previous winner so every requester gets a turn.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   from);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] ki;
        logic             found;
        int               k;
        pick  = from;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k  = (int'(from) + i) % NUM_REQ;
            ki = IDX_W'(k);
            if (!found && r[ki]) begin
                pick  = ki;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    assign next_win = rr_pick(req, last);
    assign busy     = (state != IDLE);
    assign ss_n_o   = ~gnt | {NUM_REQ{spi_ssel_n}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_timeout <= '0;
            rsp_data    <= '0;
            spi_wren    <= 1'b0;
            spi_di      <= '0;
            last        <= LAST_RST;
            owner       <= '0;
            cnt         <= '0;
        end else begin
            spi_wren    <= 1'b0;
            rsp_valid   <= '0;
            rsp_timeout <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner  <= next_win;
                        gnt    <= NUM_REQ'(1) << next_win;
                        spi_di <= data_arr[next_win];
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    spi_wren <= 1'b1;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A completion arriving in the expiry cycle wins over the timeout.
                    if (spi_do_valid || (cnt == TO_LAST)) begin
                        if (spi_do_valid) begin
                            rsp_data  <= spi_do;
                            rsp_valid <= NUM_REQ'(1) << owner;
                        end else begin
                            rsp_timeout <= NUM_REQ'(1) << owner;
                        end
                        gnt   <= '0;
                        last  <= owner;
                        cnt   <= '0;
                        state <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_share_arbiter.sv
// Randomized bench for spi_share_arbiter: an event-time reference model predicts
// every output each cycle, plus directed scenarios with hand-computed expectations.
module tb_spi_share_arbiter;

    localparam int N = 4;
    localparam int W = 20;
    localparam int G = 6;
    localparam int T = 64;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt, rsp_valid, rsp_timeout, ss_n_o;
    logic [W-1:0]   rsp_data, spi_di, spi_do;
    logic           busy, spi_wren, spi_do_valid, spi_ssel_n;

    logic           man_v, auto_v;
    logic [W-1:0]   man_do, auto_do;
    int             resp_mode;

    assign spi_do_valid = man_v | auto_v;
    assign spi_do       = man_v ? man_do : auto_do;

    int tests = 0;
    int fails = 0;

    spi_share_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
        .rsp_data(rsp_data), .busy(busy), .spi_wren(spi_wren), .spi_di(spi_di),
        .spi_do_valid(spi_do_valid), .spi_do(spi_do), .spi_ssel_n(spi_ssel_n),
        .ss_n_o(ss_n_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Reference model: tracks the owner and the edge numbers at which each
    // transaction must launch, complete or expire, and when the bus frees up.
    int           cyc, m_owner, m_grant_at, m_free_at, m_last;
    logic [N-1:0] e_gnt, e_rv, e_rt;
    logic         e_wren, e_busy;
    logic [W-1:0] e_di, e_rd;

    initial begin
        cyc = 0; m_owner = -1; m_grant_at = 0; m_free_at = 0; m_last = N - 1;
        e_gnt = '0; e_rv = '0; e_rt = '0; e_wren = 1'b0; e_busy = 1'b0;
        e_di = '0; e_rd = '0;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_owner = -1; m_free_at = 0; m_last = N - 1;
                e_gnt = '0; e_rv = '0; e_rt = '0; e_wren = 1'b0; e_busy = 1'b0;
                e_di = '0; e_rd = '0;
            end else begin
                cyc++;
                e_wren = 1'b0; e_rv = '0; e_rt = '0;
                if (m_owner >= 0) begin
                    if (cyc == m_grant_at + 1) begin
                        e_wren = 1'b1;
                    end else if (spi_do_valid || cyc == m_grant_at + 1 + T) begin
                        if (spi_do_valid) begin
                            e_rv[m_owner] = 1'b1;
                            e_rd = spi_do;
                        end else begin
                            e_rt[m_owner] = 1'b1;
                        end
                        m_last    = m_owner;
                        m_owner   = -1;
                        e_gnt     = '0;
                        m_free_at = cyc + G + 1;
                    end
                end else if (cyc >= m_free_at && req != '0) begin
                    for (int i = 1; i <= N; i++)
                        if (m_owner < 0 && req[(m_last + i) % N]) m_owner = (m_last + i) % N;
                    m_grant_at = cyc;
                    e_gnt      = N'(1) << m_owner;
                    e_di       = req_data[m_owner*W +: W];
                end
                e_busy = (m_owner >= 0) || (cyc < m_free_at - 1);
            end
        end
    end

    initial begin
        logic [N-1:0] e_ss;
        forever begin
            @(negedge clock);
            for (int k = 0; k < N; k++) e_ss[k] = e_gnt[k] ? spi_ssel_n : 1'b1;
            chk("m_gnt", 32'(gnt), 32'(e_gnt));
            chk("m_wren", 32'(spi_wren), 32'(e_wren));
            chk("m_di", 32'(spi_di), 32'(e_di));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("m_rsp_timeout", 32'(rsp_timeout), 32'(e_rt));
            chk("m_rsp_data", 32'(rsp_data), 32'(e_rd));
            chk("m_busy", 32'(busy), 32'(e_busy));
            chk("m_ss_n", 32'(ss_n_o), 32'(e_ss));
        end
    end

    // Auto responder: mode 1 answers 3 clocks after the write strobe, mode 2
    // answers after a random delay (sometimes past the timeout) and injects noise.
    initial begin
        int rcnt;
        rcnt = -1; auto_v = 1'b0; auto_do = '0;
        forever begin
            @(posedge clock);
            #2;
            auto_v = 1'b0;
            if (resp_mode != 0 && reset_n) begin
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        auto_v  = 1'b1;
                        auto_do = W'($urandom);
                        rcnt    = -1;
                    end
                end
                if (spi_wren) rcnt = (resp_mode == 1) ? 3 : int'($urandom_range(1, 75));
                if (resp_mode == 2 && rcnt < 0 && $urandom_range(0, 15) == 0) begin
                    auto_v  = 1'b1;
                    auto_do = W'($urandom);
                end
            end else begin
                rcnt = -1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) step();
        chk("idle_reached", 32'(busy), 32'd0);
        step();
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 300 && gnt == '0; i++) step();
    endtask

    task automatic wait_wren();
        for (int i = 0; i < 20 && !spi_wren; i++) step();
        chk("wren_seen", 32'(spi_wren), 32'd1);
    endtask

    initial begin
        int           n;
        logic [N-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_n = 1'b0; req = '0; req_data = '0; spi_ssel_n = 1'b1;
        man_v = 1'b0; man_do = '0; resp_mode = 0;
        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ss_n", 32'(ss_n_o), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_spi_di", 32'(spi_di), 32'd0);
        chk("rst_wren", 32'(spi_wren), 32'd0);
        reset_n = 1'b1;
        step();

        // Round-robin order with all requesters held
        resp_mode = 1;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            n = 0;
            for (int i = 0; i < 300 && gnt == '0; i++) begin step(); n++; end
            chk("rr_order", 32'(gnt), 32'(exp_seq[t]));
            if (t > 0) chk("rr_gap_ok", 32'(n >= G), 32'd1);
            if (t == 4) req = '0;
            for (int i = 0; i < 300 && gnt != '0; i++) step();
        end
        wait_idle();
        resp_mode = 0;

        // Single transaction with completion 30 clocks after the strobe
        req_data[19:0] = 20'h20009;
        req = 4'b0001;
        n = 0;
        for (int i = 0; i < 10 && !spi_wren; i++) begin step(); n++; end
        chk("wren_latency", 32'(n), 32'd2);
        chk("launch_di", 32'(spi_di), 32'h20009);
        chk("launch_gnt", 32'(gnt), 32'b0001);
        req = '0;
        repeat (29) step();
        man_v = 1'b1; man_do = 20'h12345;
        step();
        man_v = 1'b0;
        chk("done_valid", 32'(rsp_valid), 32'b0001);
        chk("done_data", 32'(rsp_data), 32'h12345);
        n = 1;
        for (int i = 0; i < 200 && busy; i++) begin step(); n++; end
        chk("busy_release", 32'(n), 32'(G + 1));
        step();

        // Timeout with no completion
        req_data[59:40] = 20'hBEEF1;
        req = 4'b0100;
        wait_wren();
        req = '0;
        chk("to_gnt", 32'(gnt), 32'b0100);
        n = 0;
        for (int i = 0; i < T + 20 && rsp_timeout == '0; i++) begin step(); n++; end
        chk("to_latency", 32'(n), 32'(T));
        chk("to_pulse", 32'(rsp_timeout), 32'b0100);
        chk("to_no_valid", 32'(rsp_valid), 32'd0);
        chk("to_data_kept", 32'(rsp_data), 32'h12345);
        wait_idle();

        // Completion coincident with the expiry cycle
        req = 4'b0010;
        wait_wren();
        req = '0;
        repeat (T - 1) step();
        man_v = 1'b1; man_do = 20'h5A5A5;
        step();
        man_v = 1'b0;
        chk("edge_valid", 32'(rsp_valid), 32'b0010);
        chk("edge_no_to", 32'(rsp_timeout), 32'd0);
        chk("edge_data", 32'(rsp_data), 32'h5A5A5);
        step();
        chk("edge_no_to_late", 32'(rsp_timeout), 32'd0);
        wait_idle();

        // Requester drops its request one cycle after the grant
        resp_mode = 1;
        req = 4'b1000;
        wait_grant();
        chk("drop_gnt", 32'(gnt), 32'b1000);
        step();
        req = '0;
        for (int i = 0; i < 50 && rsp_valid == '0; i++) step();
        chk("drop_valid", 32'(rsp_valid), 32'b1000);
        wait_idle();
        repeat (5) step();
        chk("drop_no_regrant", 32'(gnt), 32'd0);
        resp_mode = 0;

        // Reset in the middle of a WAIT
        spi_ssel_n = 1'b0;
        req = 4'b0010;
        wait_wren();
        step(); step();
        chk("pre_rst_ss_n", 32'(ss_n_o), 32'b1101);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_ss_n", 32'(ss_n_o), 32'hF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wren", 32'(spi_wren), 32'd0);
        req = 4'b1010;
        step(); step();
        reset_n = 1'b1;
        wait_grant();
        chk("post_rst_gnt", 32'(gnt), 32'b0010);
        req = '0;
        spi_ssel_n = 1'b1;
        resp_mode = 1;
        wait_idle();

        // Randomized traffic with noise on the completion strobe
        resp_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)
                for (int k = 0; k < N; k++) req_data[k*W +: W] = W'($urandom);
            spi_ssel_n = 1'($urandom_range(0, 1));
            if (c == 1500) begin
                reset_n = 1'b0;
                step(); step();
                reset_n = 1'b1;
            end
            step();
        end
        req = '0;
        resp_mode = 1;
        repeat (200) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
